sort_step_sequencer: RTL and testbench
======================================

# sort_step_sequencer

Step scheduler in front of `Sort_Engine`. It turns debounced button levels (next, prev, play) and an internal autoplay timer into single-cycle `next_step_pulse` / `prev_step_pulse` strobes. No strobe is issued while the engine is animating a swap or while the engine's sorted/at-start flags make the step meaningless. It also keeps a saturating step counter for the display.

## Interface
- `AUTO_PERIOD`, default 50_000_000: autoplay interval in clock cycles (0.5 s at 100 MHz); 26-bit timer.
- `SETTLE_CYCLES`, default 4: hold-off cycles after every strobe; must be ≥ 2.
- `clk_100mhz`  input  1  system clock, all logic on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `btn_next`  input  1  debounced level, request forward step.
- `btn_prev`  input  1  debounced level, request backward step.
- `btn_play`  input  1  debounced level, toggle autoplay.
- `engine_busy`  input  1  high while the engine shows a swap (swap_idx1 != 7).
- `is_sorted_flag`  input  1  from the engine.
- `is_at_start_flag`  input  1  from the engine.
- `next_step_pulse`  output  1  one-cycle forward strobe to the engine.
- `prev_step_pulse`  output  1  one-cycle backward strobe to the engine.
- `auto_running`  output  1  autoplay active.
- `step_count`  output  5  net steps taken, saturating 0..31.

## Operation
- **Edge detect:** one registered copy of each button; rise = level & ~prev_level.
- **Pending latches:** `next_pend` and `prev_pend`, one deep each.
  - `btn_next` rise or an autoplay tick sets `next_pend` and clears `prev_pend`.
  - `btn_prev` rise sets `prev_pend`, clears `next_pend`, and clears `auto_running`.
  - `btn_next` and `btn_prev` rising in the same cycle: both are ignored and existing pending bits are unchanged.
  - A repeat rise while already pending is absorbed; requests do not queue deeper than one.
- **Play:**
  - `btn_play` rise toggles `auto_running`, but it only sets if `is_sorted_flag` = 0.
  - `auto_running` clears in any cycle where `is_sorted_flag` = 1.
- **Autoplay timer:**
  - Counts only while `auto_running` = 1, FSM is IDLE, and `next_pend` = 0.
  - At AUTO_PERIOD−1 it produces a tick and returns to 0.
  - It clears to 0 whenever `auto_running` = 0.
- **FSM states: IDLE, ISSUE, SETTLE.**
  - **IDLE**, when `engine_busy` = 0, evaluates in priority order:
    - `prev_pend` and !`is_at_start_flag` → ISSUE(prev).
    - Otherwise `next_pend` and !`is_sorted_flag` → ISSUE(next).
    - A pending bit blocked by its flag (`prev_pend` with at_start, `next_pend` with sorted) is cleared, not held.
    - If `engine_busy` = 1, stay in IDLE with pending bits held.
  - **ISSUE** (1 cycle):
    - The selected strobe is high.
    - The matching pending bit clears.
    - `step_count` ±1, saturating: no increment at 31, no decrement at 0.
    - Next state is SETTLE.
  - **SETTLE:** a counter runs SETTLE_CYCLES cycles, then returns to IDLE. New requests latch during SETTLE but are not issued.
- `next_step_pulse` and `prev_step_pulse` are never high in the same cycle. Each is high only in ISSUE.

## Timing
- **Reset values** (asynchronous, immediate on `reset_n` low): both strobes 0, `auto_running` 0, `step_count` 0, FSM IDLE, pending bits 0, timer 0, edge registers 0.
- **Latency:**
  - Button rise first sampled at edge k → pending set after edge k.
  - Strobe is high from edge k+1 to edge k+2, provided IDLE and not busy.
- **Minimum spacing** between strobe rising edges is SETTLE_CYCLES+2 cycles.
  - This guarantees `engine_busy`, which the engine asserts one cycle after a swapping strobe, is visible before the next IDLE evaluation.
- **Autoplay:** with no stalls, consecutive strobes are AUTO_PERIOD + SETTLE_CYCLES + 2 cycles apart.
- **Reset mid-SETTLE or mid-ISSUE:** the strobe drops at once and no partial state survives.
- A held button produces exactly one request. A new request requires release followed by press.

## Test plan
- **Single next:** reset, release reset, `btn_next` high 10 cycles → exactly one `next_step_pulse` of 1 cycle, 2 cycles after the first high sample; `step_count` = 1.
- **Busy stall:** `engine_busy` = 1 for 100 cycles while `next_pend` is set → no strobe during the busy window; strobe appears 1 cycle after `engine_busy` falls; exactly one strobe total.
- **Simultaneous and conflicting requests:**
  - `btn_next` and `btn_prev` rise in the same cycle → no strobe.
  - `btn_next` rise then `btn_prev` rise during SETTLE → the next strobe is `prev_step_pulse`; `step_count` returns to 0.
- **Autoplay with AUTO_PERIOD = 20, SETTLE_CYCLES = 4:** `btn_play` pulse → strobes 26 cycles apart.
  - Raise `is_sorted_flag` → `auto_running` = 0 the next cycle, and no further strobes.
  - `btn_play` while sorted → `auto_running` stays 0.
- **Boundaries:**
  - `is_at_start_flag` = 1 plus `btn_prev` → no strobe and `prev_pend` is cleared.
  - 33 next strobes → `step_count` saturates at 31.
  - `reset_n` low mid-SETTLE → all outputs 0 immediately.

Source files
------------

// File: rtl/sort_step_sequencer.sv
// -----------------------------------------------------------------------------
// sort_step_sequencer
//
// Step scheduler in front of the sort engine. Debounced button levels and an
// internal autoplay timer become single-cycle forward/backward step strobes.
// Strobes are withheld while the engine animates a swap, and dropped when the
// engine's sorted / at-start flags make the step meaningless. A saturating
// counter tracks the net number of steps for the display.
//
// Parameters
//   AUTO_PERIOD    autoplay interval in clock cycles (26-bit timer)
//   SETTLE_CYCLES  hold-off cycles after every strobe (>= 2)
//
// Ports
//   clk_100mhz        in   system clock, rising edge
//   reset_n           in   asynchronous active-low reset
//   btn_next          in   debounced level, request forward step
//   btn_prev          in   debounced level, request backward step
//   btn_play          in   debounced level, toggle autoplay
//   engine_busy       in   engine is showing a swap
//   is_sorted_flag    in   engine reports the array sorted
//   is_at_start_flag  in   engine reports it is at the first step
//   next_step_pulse   out  one-cycle forward strobe
//   prev_step_pulse   out  one-cycle backward strobe
//   auto_running      out  autoplay active
//   step_count [4:0]  out  net steps taken, saturating 0..31
// -----------------------------------------------------------------------------
module sort_step_sequencer #(
  parameter int AUTO_PERIOD   = 50_000_000,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk_100mhz,
  input  logic       reset_n,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_play,
  input  logic       engine_busy,
  input  logic       is_sorted_flag,
  input  logic       is_at_start_flag,
  output logic       next_step_pulse,
  output logic       prev_step_pulse,
  output logic       auto_running,
  output logic [4:0] step_count
);

  localparam int                  SETTLE_W    = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [25:0]         TIMER_LAST  = 26'(AUTO_PERIOD - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_d;
  logic                next_q;
  logic                prev_q;
  logic                play_q;
  logic                next_pend;
  logic                prev_pend;
  logic                next_pend_d;
  logic                prev_pend_d;
  logic                dir_prev;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [25:0]         timer;

  logic next_rise;
  logic prev_rise;
  logic play_rise;
  logic next_req;
  logic prev_req;
  logic idle_ready;
  logic timer_en;
  logic auto_tick;
  logic issue_prev;
  logic issue_next;

  // ---------------------------------------------------------------------------
  // Button edge detection
  // ---------------------------------------------------------------------------
  // NOTE: clocked state always uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      next_q <= 1'b0;
      prev_q <= 1'b0;
      play_q <= 1'b0;
    end else begin
      next_q <= btn_next;
      prev_q <= btn_prev;
      play_q <= btn_play;
    end
  end

  assign next_rise = btn_next & ~next_q;
  assign prev_rise = btn_prev & ~prev_q;
  assign play_rise = btn_play & ~play_q;

  // Simultaneous next/prev presses are contradictory, so neither counts.
  assign next_req = next_rise & ~prev_rise;
  assign prev_req = prev_rise & ~next_rise;

  assign idle_ready = (state == IDLE) & ~engine_busy;

  // The timer pauses while a step is pending or in flight, so the autoplay
  // period is measured from the end of the previous settle window.
  assign timer_en  = auto_running & (state == IDLE) & ~next_pend;
  assign auto_tick = timer_en & (timer == TIMER_LAST);

  // Backward requests take priority; the pending bits are mutually exclusive
  // by construction, so the mask on issue_next is only a safety net.
  assign issue_prev = idle_ready & prev_pend & ~is_at_start_flag;
  assign issue_next = idle_ready & next_pend & ~is_sorted_flag & ~issue_prev;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default before the case so
  // that no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (issue_prev | issue_next) state_d = ISSUE;
      ISSUE:   state_d = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (Moore, so a reset drops the strobes immediately)
  // ---------------------------------------------------------------------------
  always_comb begin
    next_step_pulse = 1'b0;
    prev_step_pulse = 1'b0;
    if (state == ISSUE) begin
      next_step_pulse = ~dir_prev;
      prev_step_pulse = dir_prev;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue direction and settle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      dir_prev   <= 1'b0;
      settle_cnt <= '0;
    end else begin
      if (issue_prev | issue_next) begin
        dir_prev <= issue_prev;
      end
      if (state == SETTLE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end else begin
        settle_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending request latches
  // ---------------------------------------------------------------------------
  // Any pending bit is consumed by the first non-busy IDLE evaluation, whether
  // it was issued or blocked by its flag. A request arriving in that same
  // cycle is newer and overrides the consumption.
  always_comb begin
    next_pend_d = next_pend;
    prev_pend_d = prev_pend;
    if (idle_ready) begin
      next_pend_d = 1'b0;
      prev_pend_d = 1'b0;
    end
    if (prev_req) begin
      prev_pend_d = 1'b1;
      next_pend_d = 1'b0;
    end else if (next_req | auto_tick) begin
      next_pend_d = 1'b1;
      prev_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      next_pend <= 1'b0;
      prev_pend <= 1'b0;
    end else begin
      next_pend <= next_pend_d;
      prev_pend <= prev_pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Autoplay enable and timer
  // ---------------------------------------------------------------------------
  // A backward step implies the user wants manual control, so it stops
  // autoplay; a sorted array leaves nothing to play, so it blocks and clears.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      auto_running <= 1'b0;
    end else if (is_sorted_flag | prev_req) begin
      auto_running <= 1'b0;
    end else if (play_rise) begin
      auto_running <= ~auto_running;
    end
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (!auto_running || auto_tick) begin
      timer <= '0;
    end else if (timer_en) begin
      timer <= timer + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating net step counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      step_count <= '0;
    end else if (state == ISSUE) begin
      if (!dir_prev && step_count != 5'd31) begin
        step_count <= step_count + 5'd1;
      end else if (dir_prev && step_count != 5'd0) begin
        step_count <= step_count - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_sort_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sort_step_sequencer
//
// Self-checking bench for sort_step_sequencer with AUTO_PERIOD = 20 and
// SETTLE_CYCLES = 4. A cycle-level behavioural model, written in terms of
// "requests", "cycles until the scheduler is free" and "cycles counted toward
// the next autoplay step", predicts every output on every cycle. Directed
// scenarios add hand-computed expectations on strobe timing and counts.
// Inputs change just after the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_sort_step_sequencer;

  localparam int AUTO_PERIOD   = 20;
  localparam int SETTLE_CYCLES = 4;

  logic       clk_100mhz       = 1'b0;
  logic       reset_n          = 1'b0;
  logic       btn_next         = 1'b0;
  logic       btn_prev         = 1'b0;
  logic       btn_play         = 1'b0;
  logic       engine_busy      = 1'b0;
  logic       is_sorted_flag   = 1'b0;
  logic       is_at_start_flag = 1'b0;
  logic       next_step_pulse;
  logic       prev_step_pulse;
  logic       auto_running;
  logic [4:0] step_count;

  int n_pass    = 0;
  int n_checks  = 0;
  int cyc       = 0;
  int n_next    = 0;
  int n_prev    = 0;
  int last_next = -1;
  int last_prev = -1;

  sort_step_sequencer #(
    .AUTO_PERIOD  (AUTO_PERIOD),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk_100mhz      (clk_100mhz),
    .reset_n         (reset_n),
    .btn_next        (btn_next),
    .btn_prev        (btn_prev),
    .btn_play        (btn_play),
    .engine_busy     (engine_busy),
    .is_sorted_flag  (is_sorted_flag),
    .is_at_start_flag(is_at_start_flag),
    .next_step_pulse (next_step_pulse),
    .prev_step_pulse (prev_step_pulse),
    .auto_running    (auto_running),
    .step_count      (step_count)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   m_req    : pending request, 0 none, 1 forward, -1 backward
  //   m_hold   : cycles still to pass before the scheduler may issue again
  //   m_timer  : idle cycles counted toward the next autoplay request
  //   m_strobe : strobe expected in the current cycle (0, 1, -1)
  // ---------------------------------------------------------------------------
  bit m_nq, m_pq, m_yq, m_auto;
  int m_req, m_hold, m_timer, m_strobe, m_steps;

  task automatic model_reset();
    m_nq = 0; m_pq = 0; m_yq = 0; m_auto = 0;
    m_req = 0; m_hold = 0; m_timer = 0; m_strobe = 0; m_steps = 0;
  endtask

  task automatic model_step();
    bit nr, pr, yr, idle, tick;
    int s;
    nr = btn_next && !m_nq;
    pr = btn_prev && !m_pq;
    yr = btn_play && !m_yq;
    if (nr && pr) begin
      nr = 0;
      pr = 0;
    end
    // the counter shows a step one cycle after its strobe
    if (m_strobe == 1 && m_steps < 31) m_steps++;
    else if (m_strobe == -1 && m_steps > 0) m_steps--;
    idle = (m_hold == 0);
    tick = m_auto && idle && m_req != 1 && m_timer == AUTO_PERIOD - 1;
    if (!m_auto) m_timer = 0;
    else if (idle && m_req != 1) m_timer = tick ? 0 : m_timer + 1;
    if (m_hold > 0) m_hold--;
    s = 0;
    if (idle && !engine_busy) begin
      if (m_req == -1 && !is_at_start_flag) s = -1;
      else if (m_req == 1 && !is_sorted_flag) s = 1;
      m_req = 0;
    end
    if (s != 0) m_hold = SETTLE_CYCLES + 1;
    if (pr) m_req = -1;
    else if (nr || tick) m_req = 1;
    if (is_sorted_flag || pr) m_auto = 0;
    else if (yr) m_auto = !m_auto;
    m_strobe = s;
    m_nq = btn_next;
    m_pq = btn_prev;
    m_yq = btn_play;
  endtask

  initial model_reset();

  always @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare and strobe bookkeeping
  // ---------------------------------------------------------------------------
  task automatic compare_cycle();
    check("model next_step_pulse", next_step_pulse, (m_strobe == 1) ? 1 : 0);
    check("model prev_step_pulse", prev_step_pulse, (m_strobe == -1) ? 1 : 0);
    check("model auto_running", auto_running, m_auto ? 1 : 0);
    check("model step_count", step_count, m_steps);
    if (next_step_pulse) begin
      n_next++;
      last_next = cyc;
    end
    if (prev_step_pulse) begin
      n_prev++;
      last_prev = cyc;
    end
  endtask

  always @(negedge clk_100mhz) compare_cycle();

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk_100mhz);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic wait_next(input int budget, input string name, output int at);
    int base;
    base = n_next;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (n_next != base) begin
        at = last_next;
        break;
      end
    end
    if (at < 0) check({name, " timeout"}, 0, 1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " next_step_pulse"}, next_step_pulse, 0);
    check({name, " prev_step_pulse"}, prev_step_pulse, 0);
    check({name, " auto_running"}, auto_running, 0);
    check({name, " step_count"}, step_count, 0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int c0, a, b, t, pn, pp;

    step(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    step(2);

    // Single forward request held for 10 cycles
    c0 = cyc; pn = n_next;
    btn_next = 1'b1; step(10); btn_next = 1'b0; step(4);
    check("single next count", n_next - pn, 1);
    check("single next latency", last_next - c0, 2);
    check("single next step_count", step_count, 1);

    // Request latched while the engine is busy for 100 cycles
    pn = n_next;
    engine_busy = 1'b1; btn_next = 1'b1; step(2); btn_next = 1'b0; step(98);
    check("busy window strobes", n_next - pn, 0);
    c0 = cyc;
    engine_busy = 1'b0; step(8);
    check("busy release strobes", n_next - pn, 1);
    check("busy release latency", last_next - c0, 1);
    check("busy step_count", step_count, 2);

    // Simultaneous next and prev rises cancel
    pn = n_next; pp = n_prev;
    btn_next = 1'b1; btn_prev = 1'b1; step(3);
    btn_next = 1'b0; btn_prev = 1'b0; step(10);
    check("simultaneous next strobes", n_next - pn, 0);
    check("simultaneous prev strobes", n_prev - pp, 0);

    // Forward step, then a backward request during its settle window
    do_reset();
    c0 = cyc; pn = n_next; pp = n_prev;
    btn_next = 1'b1; step(1); btn_next = 1'b0; step(3);
    btn_prev = 1'b1; step(1); btn_prev = 1'b0; step(10);
    check("conflict next strobes", n_next - pn, 1);
    check("conflict next cycle", last_next - c0, 2);
    check("conflict prev strobes", n_prev - pp, 1);
    check("conflict prev cycle", last_prev - c0, 8);
    check("conflict step_count", step_count, 0);

    // Autoplay: first step after AUTO_PERIOD+2, then every PERIOD+SETTLE+2
    c0 = cyc;
    btn_play = 1'b1; step(2); btn_play = 1'b0;
    wait_next(40, "auto first", a);
    check("auto first latency", a - c0, 22);
    wait_next(40, "auto second", b);
    check("auto interval 1", b - a, 26);
    wait_next(40, "auto third", t);
    check("auto interval 2", t - b, 26);
    check("auto running before sorted", auto_running, 1);
    is_sorted_flag = 1'b1; step(1);
    check("sorted clears auto", auto_running, 0);
    pn = n_next; step(60);
    check("no strobes while sorted", n_next - pn, 0);
    btn_play = 1'b1; step(2); btn_play = 1'b0; step(2);
    check("play while sorted", auto_running, 0);
    check("auto step_count", step_count, 3);
    is_sorted_flag = 1'b0; step(2);

    // Backward request at start is dropped, not held
    pp = n_prev;
    is_at_start_flag = 1'b1; btn_prev = 1'b1; step(1); btn_prev = 1'b0; step(3);
    is_at_start_flag = 1'b0; step(10);
    check("at_start prev strobes", n_prev - pp, 0);
    check("at_start step_count", step_count, 3);

    // Backward step at zero, then saturation at 31
    do_reset();
    pp = n_prev;
    btn_prev = 1'b1; step(1); btn_prev = 1'b0; step(9);
    check("prev at zero strobes", n_prev - pp, 1);
    check("prev at zero step_count", step_count, 0);
    pn = n_next;
    for (int i = 0; i < 33; i++) begin
      btn_next = 1'b1; step(1); btn_next = 1'b0; step(7);
    end
    step(4);
    check("saturation strobes", n_next - pn, 33);
    check("saturation step_count", step_count, 31);

    // Reset during the ISSUE cycle of an autoplay step
    btn_play = 1'b1; step(2); btn_play = 1'b0;
    wait_next(40, "pre-reset strobe", a);
    check("strobe high before reset", next_step_pulse, 1);
    check("auto before reset", auto_running, 1);
    reset_n = 1'b0; #1;
    check_all_zero("reset in issue");
    step(2); reset_n = 1'b1; step(2);

    // Reset in the middle of SETTLE
    pn = n_next;
    btn_next = 1'b1; btn_play = 1'b1; step(1);
    btn_next = 1'b0; btn_play = 1'b0; step(3);
    check("pre-settle-reset strobes", n_next - pn, 1);
    check("pre-settle-reset step_count", step_count, 1);
    check("pre-settle-reset auto", auto_running, 1);
    reset_n = 1'b0; #1;
    check_all_zero("reset in settle");
    step(2); reset_n = 1'b1; step(15);
    check("no strobe after reset", n_next - pn, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
